// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default address width, stack direction encodings
// and the state set of the two-beat stack sequencer.
package cpu_pkg;

    localparam int DEFAULT_ADDR_W = 16;

    localparam logic STACK_PUSH = 1'b1;
    localparam logic STACK_POP  = 1'b0;

    typedef enum logic {
        IDLE,
        BEAT2
    } stack_state_e;

endpackage

// File: rtl/exm_stack_unit.sv
// Execute/memory stage stack sequencer: owns the stack pointer, drives the
// 16-bit data memory port and splits 32-bit PC push/pop into two beats.
module exm_stack_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_stack_operation,
    input  logic              i_stack_function,
    input  logic              i_push_pc,
    input  logic              i_pop_pc,
    input  logic [15:0]       i_data1,
    input  logic [15:0]       i_data2,
    input  logic [31:0]       i_pc,
    input  logic [15:0]       i_mem_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_mem_re,
    output logic [15:0]       o_load_data,
    output logic              o_stall,
    output logic [31:0]       o_pc_restore,
    output logic              o_pc_restore_valid,
    output logic [ADDR_W-1:0] o_sp
);

    localparam logic [ADDR_W-1:0] SP_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] SP_TWO = ADDR_W'(2);

    stack_state_e      r_state;
    stack_state_e      w_next_state;
    logic [ADDR_W-1:0] r_sp;
    logic [ADDR_W-1:0] w_sp_next;
    logic [15:0]       r_pc_lo;
    logic [15:0]       w_pc_lo_next;
    logic              w_we;
    logic              w_re;
    logic              w_stall;
    logic              w_valid;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_sp_next    = r_sp;
        w_pc_lo_next = r_pc_lo;
        w_we         = 1'b0;
        w_re         = 1'b0;
        w_stall      = 1'b0;
        w_valid      = 1'b0;
        o_mem_addr   = r_sp;
        o_mem_wdata  = 16'h0000;

        case (r_state)
            IDLE: begin
                if (i_push_pc) begin
                    o_mem_addr   = r_sp;
                    o_mem_wdata  = i_pc[31:16];
                    w_we         = 1'b1;
                    w_stall      = 1'b1;
                    w_next_state = BEAT2;
                end else if (i_pop_pc) begin
                    o_mem_addr   = r_sp + SP_ONE;
                    w_re         = 1'b1;
                    w_pc_lo_next = i_mem_rdata;
                    w_stall      = 1'b1;
                    w_next_state = BEAT2;
                end else if (i_stack_operation) begin
                    if (i_stack_function == STACK_PUSH) begin
                        o_mem_addr  = r_sp;
                        o_mem_wdata = i_data1;
                        w_we        = 1'b1;
                        w_sp_next   = r_sp - SP_ONE;
                    end else begin
                        o_mem_addr  = r_sp + SP_ONE;
                        w_re        = 1'b1;
                        w_sp_next   = r_sp + SP_ONE;
                    end
                end else if (i_mem_write) begin
                    o_mem_addr  = i_data1[ADDR_W-1:0];
                    o_mem_wdata = i_data2;
                    w_we        = 1'b1;
                end else if (i_mem_read) begin
                    o_mem_addr  = i_data1[ADDR_W-1:0];
                    w_re        = 1'b1;
                end
            end

            BEAT2: begin
                // The upstream buffer is held, so its PC op bit still selects this beat.
                w_next_state = IDLE;
                if (i_push_pc) begin
                    o_mem_addr  = r_sp - SP_ONE;
                    o_mem_wdata = i_pc[15:0];
                    w_we        = 1'b1;
                    w_sp_next   = r_sp - SP_TWO;
                end else if (i_pop_pc) begin
                    o_mem_addr  = r_sp + SP_TWO;
                    w_re        = 1'b1;
                    w_valid     = 1'b1;
                    w_sp_next   = r_sp + SP_TWO;
                end
            end

            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_sp    <= SP_RESET;
            r_pc_lo <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            r_sp    <= w_sp_next;
            r_pc_lo <= w_pc_lo_next;
        end
    end

    // Strobes are masked during reset so an aborted sequence leaves memory untouched.
    assign o_mem_we           = w_we    & ~i_reset;
    assign o_mem_re           = w_re    & ~i_reset;
    assign o_stall            = w_stall & ~i_reset;
    assign o_pc_restore_valid = w_valid & ~i_reset;
    assign o_load_data        = o_mem_re ? i_mem_rdata : 16'h0000;
    assign o_pc_restore       = {i_mem_rdata, r_pc_lo};
    assign o_sp               = r_sp;

endmodule

// File: tb/tb_exm_stack_unit.sv
// Directed bench for exm_stack_unit: a table of per-cycle vectors against a
// write-synchronous, read-combinational memory, plus a reset-abort sequence.
module tb_exm_stack_unit;

    logic        clk;
    logic        reset;
    logic        mem_read, mem_write, stack_op, stack_fn, push_pc, pop_pc;
    logic [15:0] data1, data2;
    logic [31:0] pc;
    logic [15:0] mem_rdata;
    logic [15:0] mem_addr, mem_wdata, load_data, sp;
    logic        mem_we, mem_re, stall, restore_valid;
    logic [31:0] pc_restore;

    logic [15:0] mem [0:65535];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [5:0]  ctl;     // {push_pc, pop_pc, stack_op, stack_fn, mem_write, mem_read}
        logic [15:0] d1;
        logic [15:0] d2;
        logic [31:0] pc;
        logic [15:0] e_sp;
        logic [3:0]  e_str;   // {we, re, stall, valid}
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic [15:0] e_load;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs [19];

    exm_stack_unit dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_mem_read         (mem_read),
        .i_mem_write        (mem_write),
        .i_stack_operation  (stack_op),
        .i_stack_function   (stack_fn),
        .i_push_pc          (push_pc),
        .i_pop_pc           (pop_pc),
        .i_data1            (data1),
        .i_data2            (data2),
        .i_pc               (pc),
        .i_mem_rdata        (mem_rdata),
        .o_mem_addr         (mem_addr),
        .o_mem_wdata        (mem_wdata),
        .o_mem_we           (mem_we),
        .o_mem_re           (mem_re),
        .o_load_data        (load_data),
        .o_stall            (stall),
        .o_pc_restore       (pc_restore),
        .o_pc_restore_valid (restore_valid),
        .o_sp               (sp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] ctl, input logic [15:0] d1, input logic [15:0] d2,
                                input logic [31:0] p, input logic [15:0] e_sp, input logic [3:0] e_str,
                                input logic [15:0] e_addr, input logic [15:0] e_wdata,
                                input logic [15:0] e_load, input logic [31:0] e_pc);
        vec_t v;
        v.ctl = ctl; v.d1 = d1; v.d2 = d2; v.pc = p;
        v.e_sp = e_sp; v.e_str = e_str; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_load = e_load; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic drive(input logic [5:0] ctl, input logic [15:0] d1, input logic [15:0] d2,
                         input logic [31:0] p);
        {push_pc, pop_pc, stack_op, stack_fn, mem_write, mem_read} = ctl;
        data1 = d1;
        data2 = d2;
        pc    = p;
    endtask

    task automatic compare(input string tag, input vec_t v);
        check({tag, " sp"},    32'(sp),            32'(v.e_sp));
        check({tag, " we"},    32'(mem_we),        32'(v.e_str[3]));
        check({tag, " re"},    32'(mem_re),        32'(v.e_str[2]));
        check({tag, " stall"}, 32'(stall),         32'(v.e_str[1]));
        check({tag, " valid"}, 32'(restore_valid), 32'(v.e_str[0]));
        if (v.e_str[3] || v.e_str[2]) check({tag, " addr"}, 32'(mem_addr), 32'(v.e_addr));
        if (v.e_str[3]) check({tag, " wdata"}, 32'(mem_wdata), 32'(v.e_wdata));
        if (v.e_str[2]) check({tag, " load"}, 32'(load_data), 32'(v.e_load));
        if (v.e_str[0]) check({tag, " pc_restore"}, pc_restore, v.e_pc);
    endtask

    initial begin
        // ctl: {push_pc, pop_pc, stack_op, stack_fn, mem_write, mem_read}; str: {we, re, stall, valid}
        vecs[0]  = mk(6'b000000, 16'h0000, 16'h0000, 32'h0,        16'hFFFF, 4'b0000, 16'h0,    16'h0,    16'h0,    32'h0);
        vecs[1]  = mk(6'b000010, 16'h0010, 16'hBEEF, 32'h0,        16'hFFFF, 4'b1000, 16'h0010, 16'hBEEF, 16'h0,    32'h0);
        vecs[2]  = mk(6'b000001, 16'h0010, 16'h0000, 32'h0,        16'hFFFF, 4'b0100, 16'h0010, 16'h0,    16'hBEEF, 32'h0);
        vecs[3]  = mk(6'b001100, 16'h1234, 16'h0000, 32'h0,        16'hFFFF, 4'b1000, 16'hFFFF, 16'h1234, 16'h0,    32'h0);
        vecs[4]  = mk(6'b001000, 16'h0000, 16'h0000, 32'h0,        16'hFFFE, 4'b0100, 16'hFFFF, 16'h0,    16'h1234, 32'h0);
        vecs[5]  = mk(6'b100000, 16'h0000, 16'h0000, 32'hCAFE0042, 16'hFFFF, 4'b1010, 16'hFFFF, 16'hCAFE, 16'h0,    32'h0);
        vecs[6]  = mk(6'b100000, 16'h0000, 16'h0000, 32'hCAFE0042, 16'hFFFF, 4'b1000, 16'hFFFE, 16'h0042, 16'h0,    32'h0);
        vecs[7]  = mk(6'b010000, 16'h0000, 16'h0000, 32'h0,        16'hFFFD, 4'b0110, 16'hFFFE, 16'h0,    16'h0042, 32'h0);
        vecs[8]  = mk(6'b010000, 16'h0000, 16'h0000, 32'h0,        16'hFFFD, 4'b0101, 16'hFFFF, 16'h0,    16'hCAFE, 32'hCAFE0042);
        vecs[9]  = mk(6'b001000, 16'h0000, 16'h0000, 32'h0,        16'hFFFF, 4'b0100, 16'h0000, 16'h0,    16'h0000, 32'h0);
        vecs[10] = mk(6'b001100, 16'h5A5A, 16'h0000, 32'h0,        16'h0000, 4'b1000, 16'h0000, 16'h5A5A, 16'h0,    32'h0);
        vecs[11] = mk(6'b000001, 16'h0000, 16'h0000, 32'h0,        16'hFFFF, 4'b0100, 16'h0000, 16'h0,    16'h5A5A, 32'h0);
        vecs[12] = mk(6'b101110, 16'h7777, 16'h8888, 32'h11112222, 16'hFFFF, 4'b1010, 16'hFFFF, 16'h1111, 16'h0,    32'h0);
        vecs[13] = mk(6'b111001, 16'h7777, 16'h0000, 32'h11112222, 16'hFFFF, 4'b1000, 16'hFFFE, 16'h2222, 16'h0,    32'h0);
        vecs[14] = mk(6'b011010, 16'h0000, 16'h9999, 32'h0,        16'hFFFD, 4'b0110, 16'hFFFE, 16'h0,    16'h2222, 32'h0);
        vecs[15] = mk(6'b010000, 16'h0000, 16'h0000, 32'h0,        16'hFFFD, 4'b0101, 16'hFFFF, 16'h0,    16'h1111, 32'h11112222);
        vecs[16] = mk(6'b001011, 16'h0020, 16'h0BAD, 32'h0,        16'hFFFF, 4'b0100, 16'h0000, 16'h0,    16'h5A5A, 32'h0);
        vecs[17] = mk(6'b000011, 16'h0020, 16'h0BAD, 32'h0,        16'h0000, 4'b1000, 16'h0020, 16'h0BAD, 16'h0,    32'h0);
        vecs[18] = mk(6'b000000, 16'h0000, 16'h0000, 32'h0,        16'h0000, 4'b0000, 16'h0,    16'h0,    16'h0,    32'h0);

        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;

        // Reset with requests pending: strobes must stay low.
        reset = 1'b1;
        drive(6'b100001, 16'h0010, 16'h0000, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset we",    32'(mem_we),        32'd0);
        check("reset re",    32'(mem_re),        32'd0);
        check("reset stall", 32'(stall),         32'd0);
        check("reset valid", 32'(restore_valid), 32'd0);
        check("reset sp",    32'(sp),            32'h0000FFFF);
        reset = 1'b0;
        drive(6'b000000, 16'h0000, 16'h0000, 32'h0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i].ctl, vecs[i].d1, vecs[i].d2, vecs[i].pc);
            #1;
            compare($sformatf("v%0d", i), vecs[i]);
        end
        check("mem 0010", 32'(mem[16'h0010]), 32'h0000BEEF);

        // Reset during BEAT2 of a PC push aborts the second beat.
        @(negedge clk);
        drive(6'b100000, 16'h0000, 16'h0000, 32'hABCDEF01);
        #1;
        check("abort beat1 stall", 32'(stall),     32'd1);
        check("abort beat1 addr",  32'(mem_addr),  32'h00000000);
        check("abort beat1 wdata", 32'(mem_wdata), 32'h0000ABCD);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort reset we",    32'(mem_we), 32'd0);
        check("abort reset stall", 32'(stall),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(6'b000000, 16'h0000, 16'h0000, 32'h0);
        #1;
        check("abort sp",       32'(sp),           32'h0000FFFF);
        check("abort stall",    32'(stall),        32'd0);
        check("abort mem FFFF", 32'(mem[16'hFFFF]), 32'h00001111);
        check("abort mem 0000", 32'(mem[16'h0000]), 32'h0000ABCD);

        // FSM must be back in IDLE: a fresh PC push starts with a stall beat.
        @(negedge clk);
        drive(6'b100000, 16'h0000, 16'h0000, 32'h13572468);
        #1;
        check("restart stall", 32'(stall),     32'd1);
        check("restart addr",  32'(mem_addr),  32'h0000FFFF);
        check("restart wdata", 32'(mem_wdata), 32'h00001357);
        @(negedge clk);
        #1;
        check("restart2 stall", 32'(stall),     32'd0);
        check("restart2 addr",  32'(mem_addr),  32'h0000FFFE);
        check("restart2 wdata", 32'(mem_wdata), 32'h00002468);
        @(negedge clk);
        drive(6'b000000, 16'h0000, 16'h0000, 32'h0);
        #1;
        check("restart sp", 32'(sp), 32'h0000FFFD);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exm_stack_unit.md
# exm_stack_unit

Stack and memory-port sequencer for the execute/memory stage, directly downstream of the decode/execute-memory pipeline buffer. It consumes the buffered memory and stack control bits and owns the stack pointer. It drives the 16-bit data memory port and splits 32-bit PC push/pop (CALL/RET/interrupt) into two 16-bit beats. During those beats it stalls the upstream buffer so the instruction is held for one extra cycle.

## Interface
- ADDR_W, 16, data-memory address width; SP width
- SP_RESET, {ADDR_W{1'b1}}, stack pointer value after reset (top of memory)

- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_mem_read / i_mem_write  in  1 / 1  plain load/store request
- i_stack_operation  in  1  single-word stack op
- i_stack_function  in  1  1 = push, 0 = pop
- i_push_pc / i_pop_pc  in  1 / 1  32-bit PC push / pop
- i_data1  in  16  load/store address; push data
- i_data2  in  16  store data
- i_pc  in  32  PC value to push
- i_mem_rdata  in  16  memory read data, combinational read of o_mem_addr
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  16  memory write data
- o_mem_we / o_mem_re  out  1 / 1  write / read strobes
- o_load_data  out  16  load or pop result (= i_mem_rdata when o_mem_re)
- o_stall  out  1  holds the upstream buffer (drives its i_enable low)
- o_pc_restore  out  32  popped PC
- o_pc_restore_valid  out  1  one-cycle pulse: o_pc_restore is valid
- o_sp  out  ADDR_W  current stack pointer

## Operation
- Registered state: sp, fsm (IDLE, BEAT2), pc_lo latch (16 bits). All other outputs are combinational from state and inputs.
- Request priority in IDLE: i_push_pc > i_pop_pc > i_stack_operation > i_mem_write > i_mem_read. Lower-priority requests in the same cycle are ignored.
- Plain store: addr = i_data1[ADDR_W-1:0], wdata = i_data2, we = 1. Plain load: addr = i_data1, re = 1.
- Push word: post-decrement. Write i_data1 to M[sp], then sp <= sp-1.
- Pop word: pre-increment. Read M[sp+1], then sp <= sp+1.
- Push PC, IDLE beat: write i_pc[31:16] to M[sp], assert o_stall, go to BEAT2.
- Push PC, BEAT2 beat: write i_pc[15:0] to M[sp-1], sp <= sp-2, o_stall = 0, go to IDLE.
- Pop PC, IDLE beat: read M[sp+1] into pc_lo, assert o_stall, go to BEAT2.
- Pop PC, BEAT2 beat: read M[sp+2]. o_pc_restore = {i_mem_rdata, pc_lo}, o_pc_restore_valid = 1, sp <= sp+2, go to IDLE.
- In BEAT2, the held i_push_pc/i_pop_pc selects the beat. Other request inputs are ignored.
- SP arithmetic is modulo 2^ADDR_W. Wrap at 0 / all-ones is silent, with no overflow flag.

## Timing
- Reset values: sp = SP_RESET, fsm = IDLE, pc_lo = 0. While i_reset = 1, o_mem_we, o_mem_re, o_stall and o_pc_restore_valid are forced to 0.
- Reset mid-sequence (in BEAT2) aborts the sequence. No second beat and no valid pulse occur. sp returns to SP_RESET.
- Single-word ops and plain load/store take 1 cycle with no stall. Results are visible the same cycle; the sp update is visible the next cycle.
- PC push/pop occupy 2 cycles. o_stall is high exactly in the first cycle. o_pc_restore_valid pulses in the second cycle.
- Back-to-back PC ops: after BEAT2 returns to IDLE, a new PC op starts on the next cycle. There is no bubble beyond the one stall cycle per op.
- Writes commit on the rising edge while we = 1. Memory is write-synchronous, read-combinational.

## Structure
- Shared package (cpu_pkg): ADDR_W default, the STACK_PUSH = 1 and STACK_POP = 0 encodings, and the stack-FSM state enum (IDLE, BEAT2).
- No sub-module required. An optional leaf, sp_register (reset, ±1/±2 update), is acceptable.

## Test plan
- Reset, then idle → o_sp = 16'hFFFF, all strobes 0, o_stall = 0.
- Store i_data1 = 16'h0010, i_data2 = 16'hBEEF, then load 16'h0010 → write M[0x0010] = BEEF; the next-cycle load gives o_load_data = BEEF with no stall.
- Push i_data1 = 16'h1234, then pop → M[FFFF] = 1234 and sp = FFFE; pop reads FFFF, o_load_data = 1234, sp = FFFF.
- Push PC 32'hCAFE_0042 with sp = FFFF:
  - Cycle 1: o_stall = 1, M[FFFF] = CAFE.
  - Cycle 2: M[FFFE] = 0042, sp = FFFD.
  - Pop PC then gives o_pc_restore_valid = 1 with CAFE_0042 on cycle 2, and sp = FFFF.
- Pop word at sp = FFFF → reads M[0000], sp wraps to 0000. Push at sp = 0000 → writes M[0000], sp = FFFF.
- Push PC with i_reset asserted in BEAT2 → no write to M[sp-1], o_stall = 0, sp = FFFF, fsm = IDLE next cycle.
